// File: rtl/sample_frame_sequencer_if.sv
// Frame-sequencer bus: frame counter and stage readies in, stage enables and status out.
// The sequencer connects through the slave modport; the frame source/stage side uses master.
interface sample_frame_sequencer_if #(
   parameter int unsigned CNT_W = 13
);
   logic [CNT_W-1:0] sampling_cycle_counter;
   logic             ready_conv;
   logic             ready_lag;
   logic             enable_conv;
   logic             enable_lag;
   logic             enable_d2s;
   logic             enable_echo;
   logic             enable_sampling;
   logic             busy;
   logic             overrun;
   logic [7:0]       miss_conv_cnt;
   logic [7:0]       miss_lag_cnt;

   modport master (
      output sampling_cycle_counter, ready_conv, ready_lag,
      input  enable_conv, enable_lag, enable_d2s, enable_echo, enable_sampling,
      input  busy, overrun, miss_conv_cnt, miss_lag_cnt
   );

   modport slave (
      input  sampling_cycle_counter, ready_conv, ready_lag,
      output enable_conv, enable_lag, enable_d2s, enable_echo, enable_sampling,
      output busy, overrun, miss_conv_cnt, miss_lag_cnt
   );
endinterface

// File: rtl/sample_frame_sequencer.sv
// Per-frame enable/ready sequencer for the lag16 echo-cancellation chain.
// Define SEQ_MISS_COUNT_EN to build the saturating ready-miss counters; otherwise they read 0.
module sample_frame_sequencer #(
   parameter int unsigned CNT_W          = 13,
   parameter int unsigned CONV_PULSE_CYC = 2,
   parameter int unsigned CONV_WAIT_CYC  = 25,
   parameter int unsigned LAG_PULSE_CYC  = 2,
   parameter int unsigned LAG_WAIT_CYC   = 200,
   parameter int unsigned ECHO_DELAY_CYC = 2,
   parameter int unsigned WARMUP_FRAMES  = 1
) (
   input  logic                    clk_operation,
   input  logic                    rst,
   sample_frame_sequencer_if.slave bus
);

   // A zero-length window would never expire, so every window is at least one cycle.
   localparam int unsigned CP = (CONV_PULSE_CYC == 0) ? 1 : CONV_PULSE_CYC;
   localparam int unsigned CW = (CONV_WAIT_CYC  == 0) ? 1 : CONV_WAIT_CYC;
   localparam int unsigned LP = (LAG_PULSE_CYC  == 0) ? 1 : LAG_PULSE_CYC;
   localparam int unsigned LW = (LAG_WAIT_CYC   == 0) ? 1 : LAG_WAIT_CYC;
   localparam int unsigned EW = (ECHO_DELAY_CYC == 0) ? 1 : ECHO_DELAY_CYC;
   localparam int unsigned M1 = (CP > CW) ? CP : CW;
   localparam int unsigned M2 = (LP > LW) ? LP : LW;
   localparam int unsigned M3 = (M1 > M2) ? M1 : M2;
   localparam int unsigned MAX_CYC = (M3 > EW) ? M3 : EW;
   localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned DONE_W  = $clog2(WARMUP_FRAMES + 2);

   localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
   localparam logic [TMR_W-1:0]  LD_CP    = TMR_W'(CP - 1);
   localparam logic [TMR_W-1:0]  LD_CW    = TMR_W'(CW - 1);
   localparam logic [TMR_W-1:0]  LD_LP    = TMR_W'(LP - 1);
   localparam logic [TMR_W-1:0]  LD_LW    = TMR_W'(LW - 1);
   localparam logic [TMR_W-1:0]  LD_EW    = TMR_W'(EW - 1);
   localparam logic [DONE_W-1:0] DONE_ONE = DONE_W'(1);
   localparam logic [DONE_W-1:0] DONE_MAX = DONE_W'(WARMUP_FRAMES);

   typedef enum logic [2:0] {
      IDLE, CONV_PULSE, CONV_WAIT, LAG_PULSE, LAG_WAIT, ECHO_WAIT
   } state_t;

   state_t            state, state_next;
   logic [TMR_W-1:0]  tmr, tmr_next;
   logic [DONE_W-1:0] done_cnt, done_next;
   logic              prev_zero;
   logic              frame_start, last, conv_sample, lag_sample, frame_done;
   logic              enable_conv_q, enable_lag_q, enable_d2s_q, enable_echo_q;
   logic              enable_sampling_q, busy_q, overrun_q;

   assign frame_start = (bus.sampling_cycle_counter == '0) && !prev_zero;
   assign last        = (tmr == '0);

   always_ff @(posedge clk_operation) begin
      if (!rst) begin
         state     <= IDLE;
         tmr       <= '0;
         prev_zero <= 1'b0;
         done_cnt  <= '0;
      end else begin
         // NOTE: non-blocking so every register in this edge sees the pre-edge values.
         state     <= state_next;
         tmr       <= tmr_next;
         prev_zero <= (bus.sampling_cycle_counter == '0);
         done_cnt  <= done_next;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_next  = state;
      tmr_next    = last ? '0 : tmr - TMR_ONE;
      conv_sample = 1'b0;
      lag_sample  = 1'b0;
      frame_done  = 1'b0;
      unique case (state)
         IDLE: if (frame_start) begin
            state_next = CONV_PULSE;
            tmr_next   = LD_CP;
         end
         CONV_PULSE: if (last) begin
            state_next = CONV_WAIT;
            tmr_next   = LD_CW;
         end
         CONV_WAIT: if (last) begin
            conv_sample = 1'b1;
            state_next  = LAG_PULSE;
            tmr_next    = LD_LP;
         end
         LAG_PULSE: if (last) begin
            state_next = LAG_WAIT;
            tmr_next   = LD_LW;
         end
         LAG_WAIT: if (last) begin
            lag_sample = 1'b1;
            state_next = ECHO_WAIT;
            tmr_next   = LD_EW;
         end
         ECHO_WAIT: if (last) begin
            frame_done = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      done_next = (frame_done && done_cnt != DONE_MAX) ? done_cnt + DONE_ONE : done_cnt;
   end

   // enable_lag latches the conv verdict on entry to LAG_PULSE and holds it for the window.
   always_ff @(posedge clk_operation) begin
      if (!rst) begin
         enable_conv_q     <= 1'b0;
         enable_lag_q      <= 1'b0;
         enable_d2s_q      <= 1'b0;
         enable_echo_q     <= 1'b0;
         enable_sampling_q <= 1'b0;
         busy_q            <= 1'b0;
         overrun_q         <= 1'b0;
      end else begin
         enable_conv_q     <= (state_next == CONV_PULSE);
         enable_lag_q      <= (state_next == LAG_PULSE) &&
                              (conv_sample ? bus.ready_conv : enable_lag_q);
         enable_d2s_q      <= enable_d2s_q | (lag_sample & bus.ready_lag);
         enable_echo_q     <= enable_echo_q | frame_done;
         enable_sampling_q <= enable_sampling_q | (done_next >= DONE_MAX);
         busy_q            <= (state_next != IDLE);
         overrun_q         <= frame_start && (state != IDLE);
      end
   end

   assign bus.enable_conv     = enable_conv_q;
   assign bus.enable_lag      = enable_lag_q;
   assign bus.enable_d2s      = enable_d2s_q;
   assign bus.enable_echo     = enable_echo_q;
   assign bus.enable_sampling = enable_sampling_q;
   assign bus.busy            = busy_q;
   assign bus.overrun         = overrun_q;

`ifdef SEQ_MISS_COUNT_EN
   logic [7:0] miss_conv_q, miss_lag_q;

   always_ff @(posedge clk_operation) begin
      if (!rst) begin
         miss_conv_q <= 8'd0;
         miss_lag_q  <= 8'd0;
      end else begin
         if (conv_sample && !bus.ready_conv && miss_conv_q != 8'hFF)
            miss_conv_q <= miss_conv_q + 8'd1;
         if (lag_sample && !bus.ready_lag && miss_lag_q != 8'hFF)
            miss_lag_q <= miss_lag_q + 8'd1;
      end
   end

   assign bus.miss_conv_cnt = miss_conv_q;
   assign bus.miss_lag_cnt  = miss_lag_q;
`else
   assign bus.miss_conv_cnt = 8'd0;
   assign bus.miss_lag_cnt  = 8'd0;
`endif

endmodule
